// File: rtl/seq_disp_pkg.sv
// Shared types and constants for the sequence display stage.
// Holds the FSM encoding, the active-low segment codes and default sequence bounds.
package seq_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        FLASH_OFF,
        FLASH_ON
    } state_e;

    localparam int DEF_START_VAL = 5;
    localparam int DEF_END_VAL   = 8;

    // Active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seq_disp_ctrl_seg7.sv
// BCD digit to active-low 7-segment decoder with a blanking input.
// Codes above 9 are shown blank.
module seg7_dec_bcd
    import seq_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seq_disp_ctrl.sv
// Display stage for the sequence player: captures values, shows two digits,
// and flashes the display for a fixed time whenever the sequence wraps.
module seq_disp_ctrl
    import seq_disp_pkg::*;
#(
    parameter int N            = 4,
    parameter int START_VAL    = DEF_START_VAL,
    parameter int END_VAL      = DEF_END_VAL,
    parameter int FLASH_CYCLES = 4
) (
    input  logic         clk_500ms,
    input  logic         reset,
    input  logic [N-1:0] val_in,
    input  logic         val_valid,
    input  logic         dir_up,
    output logic [6:0]   seg1,
    output logic [6:0]   seg0,
    output logic         wrap,
    output logic         busy
);

    localparam int CW = $clog2(FLASH_CYCLES) + 1;

    state_e          state_q, state_d;
    logic [N-1:0]    val_q;
    logic            have_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wrap_q;
    logic            is_wrap;
    logic            show;
    logic            tens;
    logic [N-1:0]    units;

    // At the capture edge val_q still holds the previous value
    assign is_wrap = val_valid && have_q &&
        (( dir_up && val_q == N'(END_VAL)   && val_in == N'(START_VAL)) ||
         (!dir_up && val_q == N'(START_VAL) && val_in == N'(END_VAL)));

    always_ff @(posedge clk_500ms or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            val_q   <= '0;
            have_q  <= 1'b0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= is_wrap;
            if (val_valid) begin
                val_q  <= val_in;
                have_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (val_valid) state_d = SHOW;
            end
            SHOW: ;
            FLASH_OFF: begin
                state_d = FLASH_ON;
                cnt_d   = cnt_q - 1'b1;
            end
            FLASH_ON: begin
                if (cnt_q != '0) begin
                    state_d = FLASH_OFF;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    state_d = SHOW;
                end
            end
            default: state_d = IDLE;
        endcase
        if (is_wrap) begin
            state_d = FLASH_OFF;
            cnt_d   = CW'(FLASH_CYCLES - 1);
        end
    end

    assign show  = (state_q == SHOW) || (state_q == FLASH_ON);
    assign tens  = (val_q >= N'(10));
    assign units = tens ? val_q - N'(10) : val_q;

    seg7_dec_bcd u_tens (
        .bcd_i   ({3'b000, tens}),
        .blank_i (!show || !tens),
        .seg_o   (seg1)
    );

    seg7_dec_bcd u_units (
        .bcd_i   (units[3:0]),
        .blank_i (!show),
        .seg_o   (seg0)
    );

    assign wrap = wrap_q;
    assign busy = (state_q == FLASH_OFF) || (state_q == FLASH_ON);

endmodule

// File: tb/tb_seq_disp_ctrl.sv
// Self-checking bench for seq_disp_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_seq_disp_ctrl;

    localparam int N  = 4;
    localparam int SV = 5;
    localparam int EV = 8;
    localparam int FC = 4;
    localparam logic [6:0] BLK = 7'b1111111;

    logic         clk_500ms = 0;
    logic         reset = 0;
    logic [N-1:0] val_in = '0;
    logic         val_valid = 0;
    logic         dir_up = 1;
    logic [6:0]   seg1, seg0;
    logic         wrap, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] digit_tbl [10];

    // Model: latest value, whether any value seen, flash cycles remaining
    int m_val  = 0;
    bit m_have = 0;
    int m_left = 0;
    bit m_wrap = 0;

    seq_disp_ctrl #(
        .N(N), .START_VAL(SV), .END_VAL(EV), .FLASH_CYCLES(FC)
    ) dut (
        .clk_500ms (clk_500ms),
        .reset     (reset),
        .val_in    (val_in),
        .val_valid (val_valid),
        .dir_up    (dir_up),
        .seg1      (seg1),
        .seg0      (seg0),
        .wrap      (wrap),
        .busy      (busy)
    );

    always #5 clk_500ms = ~clk_500ms;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit model_wrap(bit have, int prev, int nv, bit up);
        if (!have) return 0;
        if (up) return (prev == EV) && (nv == SV);
        return (prev == SV) && (nv == EV);
    endfunction

    always @(posedge clk_500ms or posedge reset) begin
        if (reset) begin
            m_val  <= 0;
            m_have <= 0;
            m_left <= 0;
            m_wrap <= 0;
        end else begin
            if (val_valid && model_wrap(m_have, m_val, int'(val_in), dir_up)) begin
                m_wrap <= 1;
                m_left <= FC;
            end else begin
                m_wrap <= 0;
                m_left <= (m_left > 0) ? m_left - 1 : 0;
            end
            if (val_valid) begin
                m_val  <= int'(val_in);
                m_have <= 1;
            end
        end
    end

    function automatic bit m_blank();
        if (!m_have) return 1;
        return (m_left > 0) && (((FC - m_left) % 2) == 0);
    endfunction

    always @(negedge clk_500ms) begin
        logic [6:0] e1, e0;
        e1 = (m_blank() || m_val < 10) ? BLK : digit_tbl[1];
        e0 = m_blank() ? BLK : digit_tbl[m_val % 10];
        chk("model_seg1", {25'd0, seg1}, {25'd0, e1});
        chk("model_seg0", {25'd0, seg0}, {25'd0, e0});
        chk("model_wrap", {31'd0, wrap}, {31'd0, m_wrap});
        chk("model_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    end

    task automatic cap(input int v, input bit up);
        val_in    = N'(v);
        dir_up    = up;
        val_valid = 1;
        @(posedge clk_500ms);
        #1;
        val_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_500ms);
        #1;
    endtask

    initial begin
        digit_tbl[0] = 7'b1000000; digit_tbl[1] = 7'b1111001;
        digit_tbl[2] = 7'b0100100; digit_tbl[3] = 7'b0110000;
        digit_tbl[4] = 7'b0011001; digit_tbl[5] = 7'b0010010;
        digit_tbl[6] = 7'b0000010; digit_tbl[7] = 7'b1111000;
        digit_tbl[8] = 7'b0000000; digit_tbl[9] = 7'b0010000;

        #1 reset = 1;
        #12 reset = 0;
        idle(2);
        chk("rst_seg1", {25'd0, seg1}, 32'h7f);
        chk("rst_seg0", {25'd0, seg0}, 32'h7f);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_wrap", {31'd0, wrap}, 0);

        cap(5, 1);
        chk("c5_seg1", {25'd0, seg1}, 32'h7f);
        chk("c5_seg0", {25'd0, seg0}, {25'd0, 7'b0010010});
        cap(10, 1);
        chk("c10_seg1", {25'd0, seg1}, {25'd0, 7'b1111001});
        chk("c10_seg0", {25'd0, seg0}, {25'd0, 7'b1000000});
        cap(15, 1);
        chk("c15_seg1", {25'd0, seg1}, {25'd0, 7'b1111001});
        chk("c15_seg0", {25'd0, seg0}, {25'd0, 7'b0010010});
        chk("c15_wrap", {31'd0, wrap}, 0);

        cap(3, 1);
        cap(8, 1);
        chk("up8_wrap", {31'd0, wrap}, 0);
        cap(5, 1);
        chk("upw_wrap", {31'd0, wrap}, 1);
        chk("upw_busy0", {31'd0, busy}, 1);
        chk("upw_off0", {25'd0, seg0}, 32'h7f);
        idle(1);
        chk("upw_wrap_clr", {31'd0, wrap}, 0);
        chk("upw_on1", {25'd0, seg0}, {25'd0, 7'b0010010});
        idle(1);
        chk("upw_off2", {25'd0, seg0}, 32'h7f);
        chk("upw_busy2", {31'd0, busy}, 1);
        idle(1);
        chk("upw_on3", {25'd0, seg0}, {25'd0, 7'b0010010});
        chk("upw_busy3", {31'd0, busy}, 1);
        idle(1);
        chk("upw_show", {25'd0, seg0}, {25'd0, 7'b0010010});
        chk("upw_busy_end", {31'd0, busy}, 0);

        cap(10, 0);
        cap(5, 0);
        chk("dn5_wrap", {31'd0, wrap}, 0);
        cap(8, 0);
        chk("dnw_wrap", {31'd0, wrap}, 1);
        cap(4, 0);
        chk("dn4_on_seg0", {25'd0, seg0}, {25'd0, 7'b0011001});
        chk("dn4_busy", {31'd0, busy}, 1);
        idle(1);
        chk("dn4_off", {25'd0, seg0}, 32'h7f);
        idle(1);
        chk("dn4_on2", {25'd0, seg0}, {25'd0, 7'b0011001});
        chk("dn4_busy2", {31'd0, busy}, 1);
        idle(1);
        chk("dn4_show", {25'd0, seg0}, {25'd0, 7'b0011001});
        chk("dn4_busy_end", {31'd0, busy}, 0);

        cap(8, 1);
        cap(5, 1);
        idle(1);
        cap(8, 0);
        chk("rw_wrap", {31'd0, wrap}, 1);
        chk("rw_b0", {31'd0, busy}, 1);
        chk("rw_seg0_off", {25'd0, seg0}, 32'h7f);
        for (int i = 1; i < FC; i++) begin
            idle(1);
            chk("rw_bi", {31'd0, busy}, 1);
        end
        idle(1);
        chk("rw_end", {31'd0, busy}, 0);
        chk("rw_seg0", {25'd0, seg0}, {25'd0, 7'b0000000});

        cap(5, 1);
        idle(1);
        chk("pre_rst_on", {31'd0, busy}, 1);
        reset = 1;
        #1;
        chk("mid_rst_seg1", {25'd0, seg1}, 32'h7f);
        chk("mid_rst_seg0", {25'd0, seg0}, 32'h7f);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_wrap", {31'd0, wrap}, 0);
        #1 reset = 0;
        @(posedge clk_500ms);
        #1;
        cap(5, 1);
        chk("post_rst_wrap", {31'd0, wrap}, 0);
        chk("post_rst_busy", {31'd0, busy}, 0);
        chk("post_rst_seg0", {25'd0, seg0}, {25'd0, 7'b0010010});

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1;
                #2 reset = 0;
            end
            if ($urandom_range(0, 9) < 6) begin
                cap(r < 3 ? SV : (r < 6 ? EV : $urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
            end else begin
                idle(1);
            end
        end
        idle(FC + 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
